// File: rtl/denorm32.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : denorm32
//  Description : Two-stage pipelined 32-bit logical right shifter with sticky
//                bit, used to denormalize a value by a leading-zero count.
//                Stage 1 shifts by whole bytes; stage 2 shifts by the
//                residual 0..7 bits. Valid/ready handshake on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module denorm32 (
    input  logic        clock,
    input  logic        reset,
    input  logic        I_Valid,
    input  logic [31:0] I_Data,
    input  logic [4:0]  I_Num,
    output logic        O_Ready,
    output logic        O_Valid,
    output logic [31:0] O_Data,
    output logic        O_Sticky,
    input  logic        I_Ready,
    output logic        O_Busy
);

    localparam int unsigned c_DATA_W = 32;
    localparam int unsigned c_FINE_W = 3;

    // Stage 1 registers: byte-shifted data, residual count, partial sticky
    logic                r_s1_valid;
    logic [c_DATA_W-1:0] r_s1_data;
    logic [c_FINE_W-1:0] r_s1_fine;
    logic                r_s1_sticky;

    // Stage 2 registers: the block outputs
    logic                r_s2_valid;
    logic [c_DATA_W-1:0] r_s2_data;
    logic                r_s2_sticky;

    // Pipeline control
    logic                w_s2_en;
    logic                w_s1_en;

    // Datapath
    logic [c_DATA_W-1:0] w_byte_data;
    logic                w_byte_sticky;
    logic [c_DATA_W-1:0] w_fine_data;
    logic [7:0]          w_fine_mask;
    logic                w_fine_sticky;

    // Stage 2 can take a new item when it is empty or draining this cycle;
    // stage 1 can take one when it is empty or advancing into stage 2.
    assign w_s2_en = !r_s2_valid || I_Ready;
    assign w_s1_en = !r_s1_valid || w_s2_en;

    // Coarse shift by I_Num[4:3] whole bytes; the bytes dropped feed sticky
    always_comb begin
        w_byte_data   = I_Data;
        w_byte_sticky = 1'b0;
        case (I_Num[4:3])
            2'd1: begin
                w_byte_data   = {8'h00, I_Data[31:8]};
                w_byte_sticky = |I_Data[7:0];
            end
            2'd2: begin
                w_byte_data   = {16'h0000, I_Data[31:16]};
                w_byte_sticky = |I_Data[15:0];
            end
            2'd3: begin
                w_byte_data   = {24'h000000, I_Data[31:24]};
                w_byte_sticky = |I_Data[23:0];
            end
            default: begin
                w_byte_data   = I_Data;
                w_byte_sticky = 1'b0;
            end
        endcase
    end

    // Fine shift by 0..7 bits; only the low byte can be shifted out here
    assign w_fine_data   = r_s1_data >> r_s1_fine;
    assign w_fine_mask   = ~(8'hFF << r_s1_fine);
    assign w_fine_sticky = r_s1_sticky | (|(r_s1_data[7:0] & w_fine_mask));

    // Stage 1: capture an accepted input, otherwise hold or empty out
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_data   <= '0;
            r_s1_fine   <= '0;
            r_s1_sticky <= 1'b0;
        end else if (w_s1_en) begin
            r_s1_valid <= I_Valid;
            if (I_Valid) begin
                r_s1_data   <= w_byte_data;
                r_s1_fine   <= I_Num[2:0];
                r_s1_sticky <= w_byte_sticky;
            end
        end
    end

    // Stage 2: load from stage 1; data only changes when a real item arrives
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s2_valid  <= 1'b0;
            r_s2_data   <= '0;
            r_s2_sticky <= 1'b0;
        end else if (w_s2_en) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data   <= w_fine_data;
                r_s2_sticky <= w_fine_sticky;
            end
        end
    end

    assign O_Ready  = w_s1_en;
    assign O_Valid  = r_s2_valid;
    assign O_Data   = r_s2_data;
    assign O_Sticky = r_s2_sticky;
    assign O_Busy   = r_s1_valid | r_s2_valid;

endmodule
`default_nettype wire

// File: tb/tb_denorm32.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_denorm32
//  Description : Self-checking bench for denorm32 with a scoreboard queue
//                fed on input handshakes and drained on output handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_denorm32;

    logic        clock   = 1'b0;
    logic        reset   = 1'b1;
    logic        I_Valid = 1'b0;
    logic [31:0] I_Data  = '0;
    logic [4:0]  I_Num   = '0;
    logic        I_Ready = 1'b0;
    logic        O_Ready;
    logic        O_Valid;
    logic [31:0] O_Data;
    logic        O_Sticky;
    logic        O_Busy;

    int          n_checks  = 0;
    int          n_errors  = 0;
    int          out_count = 0;
    int          base_count;
    logic [32:0] sb[$];
    logic        prev_stall  = 1'b0;
    logic [31:0] prev_data   = '0;
    logic [32:0] exp_a;

    denorm32 dut (
        .clock    (clock),
        .reset    (reset),
        .I_Valid  (I_Valid),
        .I_Data   (I_Data),
        .I_Num    (I_Num),
        .O_Ready  (O_Ready),
        .O_Valid  (O_Valid),
        .O_Data   (O_Data),
        .O_Sticky (O_Sticky),
        .I_Ready  (I_Ready),
        .O_Busy   (O_Busy)
    );

    always #5 clock = ~clock;

    // Reference: {sticky, data >> n}, sticky = OR of the n bits dropped
    function automatic logic [32:0] model(logic [31:0] d, logic [4:0] n);
        logic s;
        s = 1'b0;
        for (int i = 0; i < 32; i++)
            if (i < int'(n)) s = s | d[i];
        return {s, d >> n};
    endfunction

    function automatic void check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endfunction

    // Monitor between rising edges: handshake signals are stable here and
    // describe the transfers that the next rising edge will perform.
    always @(negedge clock) begin
        if (reset) begin
            check("busy_vs_inflight", {63'b0, O_Busy}, {63'b0, sb.size() != 0});
            check("ready_vs_occupancy", {63'b0, O_Ready},
                  {63'b0, (sb.size() < 2) || I_Ready});
            if (prev_stall) begin
                check("stall_hold_valid", {63'b0, O_Valid}, 64'd1);
                check("stall_hold_data", {32'b0, O_Data}, {32'b0, prev_data});
            end
            if (O_Valid && I_Ready) begin
                check("output_has_item", {63'b0, sb.size() != 0}, 64'd1);
                if (sb.size() != 0) begin
                    check("out_data_sticky", {31'b0, O_Sticky, O_Data}, {31'b0, sb[0]});
                    void'(sb.pop_front());
                end
                out_count <= out_count + 1;
            end
            if (I_Valid && O_Ready)
                sb.push_back(model(I_Data, I_Num));
            prev_stall <= O_Valid && !I_Ready;
            prev_data  <= O_Data;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    task automatic cyc(int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send(logic [31:0] d, logic [4:0] n);
        I_Valid = 1'b1;
        I_Data  = d;
        I_Num   = n;
        cyc();
    endtask

    task automatic drain();
        int k;
        k = 0;
        I_Valid = 1'b0;
        I_Ready = 1'b1;
        while ((sb.size() != 0 || O_Busy) && k < 50) begin
            cyc();
            k++;
        end
        check("drain_done", {63'b0, (sb.size() == 0) && !O_Busy}, 64'd1);
    endtask

    initial begin
        // Asynchronous reset with inputs active, before any clock edge
        #1;
        I_Valid = 1'b1;
        I_Ready = 1'b0;
        I_Data  = 32'hFFFF_FFFF;
        reset   = 1'b0;
        #2;
        check("rst_valid",  {63'b0, O_Valid},  64'd0);
        check("rst_busy",   {63'b0, O_Busy},   64'd0);
        check("rst_data",   {32'b0, O_Data},   64'd0);
        check("rst_sticky", {63'b0, O_Sticky}, 64'd0);
        check("rst_ready",  {63'b0, O_Ready},  64'd1);
        cyc(2);
        check("rst_hold_valid", {63'b0, O_Valid}, 64'd0);
        check("rst_hold_busy",  {63'b0, O_Busy},  64'd0);

        // Release and transfer on the very first edge; check 2-cycle latency
        reset   = 1'b1;
        I_Ready = 1'b1;
        I_Valid = 1'b1;
        I_Data  = 32'h8000_00FF;
        I_Num   = 5'd8;
        cyc();
        check("first_xfer_busy",  {63'b0, O_Busy},  64'd1);
        check("lat_not_yet",      {63'b0, O_Valid}, 64'd0);
        I_Valid = 1'b0;
        cyc();
        check("lat_valid",  {63'b0, O_Valid},  64'd1);
        check("lat_data",   {32'b0, O_Data},   64'h0000_0000_0080_0000);
        check("lat_sticky", {63'b0, O_Sticky}, 64'd1);
        drain();

        // Boundary values
        send(32'hDEAD_BEEF, 5'd0);
        send(32'h8000_0001, 5'd31);
        send(32'h0000_0000, 5'd17);
        send(32'h0000_0000, 5'd0);
        send(32'hFFFF_FFFF, 5'd31);
        send(32'h1234_5678, 5'd4);
        send(32'h0000_0080, 5'd8);
        drain();

        // Streaming: 16 back-to-back items, outputs on consecutive cycles
        base_count = out_count;
        for (int i = 0; i < 16; i++)
            send($urandom, 5'((i * 3) % 32));
        I_Valid = 1'b0;
        cyc(2);
        check("stream_count", 64'(out_count - base_count), 64'd16);
        drain();

        // Backpressure: downstream stalled for 5 cycles while inputs offered
        I_Ready = 1'b0;
        exp_a = model(32'hA5A5_0F0F, 5'd12);
        send(32'hA5A5_0F0F, 5'd12);
        send(32'h1357_9BDF, 5'd3);
        check("bp_ready_low",  {63'b0, O_Ready}, 64'd0);
        check("bp_valid",      {63'b0, O_Valid}, 64'd1);
        check("bp_head_data",  {32'b0, O_Data},  {32'b0, exp_a[31:0]});
        I_Data = 32'hCAFE_F00D;
        I_Num  = 5'd20;
        cyc(3);
        check("bp_ready_still_low", {63'b0, O_Ready}, 64'd0);
        check("bp_head_held",       {32'b0, O_Data},  {32'b0, exp_a[31:0]});
        I_Ready = 1'b1;
        #1;
        check("bp_ready_release", {63'b0, O_Ready}, 64'd1);
        cyc();
        drain();

        // Reset with both stages full: everything in flight is discarded
        I_Ready = 1'b0;
        send(32'h0F0F_0F0F, 5'd1);
        send(32'hF0F0_F0F0, 5'd9);
        I_Valid = 1'b0;
        check("full_before_rst", {63'b0, O_Busy && O_Valid}, 64'd1);
        reset = 1'b0;
        sb.delete();
        #1;
        check("midrst_valid", {63'b0, O_Valid}, 64'd0);
        check("midrst_busy",  {63'b0, O_Busy},  64'd0);
        check("midrst_ready", {63'b0, O_Ready}, 64'd1);
        check("midrst_data",  {32'b0, O_Data},  64'd0);
        cyc(2);
        reset   = 1'b1;
        I_Ready = 1'b1;
        cyc(4);
        check("no_stale_valid", {63'b0, O_Valid}, 64'd0);
        check("no_stale_busy",  {63'b0, O_Busy},  64'd0);

        // Random traffic with random backpressure
        for (int i = 0; i < 10000; i++) begin
            I_Valid = 1'($urandom_range(0, 1));
            I_Ready = ($urandom_range(0, 3) != 0);
            I_Data  = ($urandom_range(0, 15) == 0) ? 32'h0 : $urandom;
            I_Num   = 5'($urandom_range(0, 31));
            cyc();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/denorm32.md
DENORM32 -- requirements
Module: denorm32

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits and shift width at 5 bits.
REQ-002 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 I_Valid  input  1  upstream request: I_Data/I_Num are valid.
REQ-005 I_Data  input  32  normalized value to denormalize.
REQ-006 I_Num  input  5  right-shift count, as produced by the team's 32-bit leading-zero counter.
REQ-007 O_Ready  output  1  block can accept an input this cycle.
REQ-008 O_Valid  output  1  O_Data/O_Sticky are valid.
REQ-009 O_Data  output  32  I_Data logically right-shifted by I_Num, zero-filled.
REQ-010 O_Sticky  output  1  OR of all bits shifted out below bit 0.
REQ-011 I_Ready  input  1  downstream accepts the output this cycle.
REQ-012 O_Busy  output  1  at least one pipeline stage holds valid data.

Function
REQ-013 An input transfer SHALL occur when I_Valid and O_Ready are both 1 on a rising edge; an output transfer SHALL occur when O_Valid and I_Ready are both 1.
REQ-014 The block SHALL be a two-stage pipeline:
- Stage 1 shifts by I_Num[4:3]*8 (byte shift) and registers data, residual count I_Num[2:0], partial sticky and a valid bit.
- Stage 2 shifts by the residual 0..7 bits and registers O_Data, O_Sticky and O_Valid.
REQ-015 Latency from input transfer to O_Valid=1 SHALL be exactly 2 cycles when downstream is not stalling; sustained throughput SHALL be one transfer per cycle.
REQ-016 Stage 2 SHALL load from stage 1 when stage 2 is empty or stage 2 transfers out in the same cycle.
REQ-017 Stage 1 SHALL load from the input when stage 1 is empty or stage 1 advances to stage 2 in the same cycle.
REQ-018 O_Ready SHALL be combinational: (stage-1 valid == 0) OR (stage 2 empty OR I_Ready).
REQ-019 A stage SHALL hold its data and valid bit unchanged while stalled; O_Data SHALL stay stable while O_Valid=1 and I_Ready=0.
REQ-020 Simultaneous input transfer, stage advance and output transfer in one cycle SHALL lose and duplicate no item.
REQ-021 O_Sticky SHALL be 1 iff any bit of I_Data[I_Num-1:0] is 1; for I_Num=0 it SHALL be 0.
REQ-022 Boundary cases:
- I_Num=0: O_Data SHALL equal I_Data.
- I_Num=31: O_Data SHALL equal {31'b0, I_Data[31]}.
- I_Data=0: O_Data=0 and O_Sticky=0 for any I_Num.
REQ-023 O_Busy SHALL be the OR of the stage-1 and stage-2 valid bits.
REQ-024 When no item is valid, O_Data and O_Sticky SHALL hold their last values; consumers SHALL qualify them with O_Valid.

Reset
REQ-025 On reset=0, asynchronously and regardless of I_Valid or I_Ready:
- both stage valid bits SHALL clear to 0;
- O_Valid=0, O_Busy=0, O_Data=32'h0, O_Sticky=0;
- O_Ready SHALL read 1.
REQ-026 Items in flight when reset asserts SHALL be discarded; none SHALL appear after reset releases.
REQ-027 The first input transfer SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-028 Basic shift: I_Data=32'h8000_00FF, I_Num=8, I_Ready=1 -> two cycles later O_Valid=1, O_Data=32'h0080_0000, O_Sticky=1.
REQ-029 Boundary values:
- I_Num=0 with I_Data=32'hDEAD_BEEF -> O_Data=32'hDEAD_BEEF, O_Sticky=0.
- I_Num=31 with I_Data=32'h8000_0001 -> O_Data=32'h0000_0001, O_Sticky=1.
REQ-030 Streaming: 16 back-to-back inputs with I_Ready=1 -> 16 outputs in order on consecutive cycles, O_Ready constantly 1.
REQ-031 Backpressure: I_Ready=0 for 5 cycles while inputs are offered -> after 2 items are accepted O_Ready=0; O_Data is held stable; on release all items drain in order with no loss.
REQ-032 Reset mid-operation: assert reset with both stages valid -> O_Valid=0 and O_Busy=0 immediately; no stale output after release.
REQ-033 Random stimulus: random I_Data, I_Num, I_Valid and I_Ready over 10k cycles -> scoreboard matches the (I_Data >> I_Num, sticky) reference model for every transfer.
